hilo_muldiv_controller: RTL and testbench
=========================================

// Module: hilo_muldiv_controller
// PURPOSE
//  Sequences multiply, divide and move-to operations into the HI/LO register file.
//  Accepts one op at a time from the execute stage and drives Busy so the core stalls.
//  Computes the full 64-bit result, including 64-bit carry for MADD/MSUB, using the current HiIn/LoIn.
//  Writes the HI/LO file only through WriteEn plus data; it never uses the file's Madd/Msub inputs.
// PARAMETERS
//  MUL_STAGES  2  cycles spent in MUL before writeback (models pipelined multiplier), >=1
// PORTS
//  Clk          in   1   clock, all state updates on posedge
//  Rst          in   1   synchronous active-high reset
//  Start        in   1   request; sampled only in IDLE
//  Op           in   4   0 MULT,1 MULTU,2 MADD,3 MADDU,4 MSUB,5 MSUBU,6 DIV,7 DIVU,8 MTHI,9 MTLO
//  A            in   32  rs operand (dividend / MTHI,MTLO source)
//  B            in   32  rt operand (divisor)
//  HiIn         in   32  current HI from the HI/LO file
//  LoIn         in   32  current LO from the HI/LO file
//  Busy         out  1   op in flight; Start ignored while high
//  WriteEn      out  1   one-cycle write strobe to the HI/LO file
//  WriteHiData  out  32  HI value written with WriteEn
//  WriteLoData  out  32  LO value written with WriteEn
//  DivZero      out  1   (HILO_CTRL_DIVZERO_EN only) one-cycle divide-by-zero flag
// BEHAVIOUR
//  Reset: state IDLE; Busy=0, WriteEn=0, WriteHiData=WriteLoData=0, DivZero=0; op in flight discarded, no write.
//  States: IDLE, MUL, DIV, FIX, WB.
//  IDLE: Start=1 with valid Op latches A, B and Op. Op 0-5 goes to MUL, 6-7 to DIV, 8-9 to WB.
//   Op 10-15 is ignored: stay IDLE, no write. Busy goes high the cycle after accept.
//  MUL: MUL_STAGES cycles, then WB. Signed ops use a 64-bit two's-complement product; unsigned ops zero-extend.
//  DIV: 32 cycles of restoring division on magnitudes, one quotient bit per cycle, then FIX.
//  FIX: 1 cycle. Quotient is negated if sign(A)^sign(B) for DIV; remainder takes the sign of A. DIVU is unchanged.
//  WB: WriteEn=1 for exactly this cycle, then IDLE. Busy=0 the cycle after WB.
//   MULT/MULTU: {Hi,Lo} = product.
//   MADD(U): {Hi,Lo} = {HiIn,LoIn} + product. MSUB(U): {Hi,Lo} = {HiIn,LoIn} - product. Mod 2^64, carry crosses Lo->Hi.
//   HiIn/LoIn are sampled in the WB cycle.
//   DIV/DIVU: Lo = quotient, Hi = remainder.
//   MTHI: Hi=A, Lo=LoIn. MTLO: Lo=A, Hi=HiIn.
//  Latency from accept edge to WriteEn high:
//   mul family: MUL_STAGES+1 cycles; div: 34 cycles; MTHI/MTLO: 1 cycle.
//  WriteHiData/WriteLoData hold their last written values outside WB.
//  Start while Busy, or in the WB cycle, is ignored (not queued).
//  Start in the cycle after WB is accepted, so back-to-back throughput is one op per latency+1 cycles.
//  Signed DIV 0x80000000 / -1: Lo=0x80000000, Hi=0 (wraps, no trap).
// CONFIGURATION
//  HILO_CTRL_DIVZERO_EN defined:
//   DIV/DIVU with B==0 goes IDLE->WB without a write: WriteEn stays 0 and DivZero=1 in that cycle. HI/LO are unchanged.
//  HILO_CTRL_DIVZERO_EN undefined:
//   DivZero port is absent and B==0 runs the normal algorithm.
//   Raw result is quotient 0xFFFFFFFF and remainder |A|; FIX applies, then it is written.
// TESTING
//  MULT A=-3 B=5, MUL_STAGES=2 -> WriteEn at cycle 3, Hi=FFFFFFFF, Lo=FFFFFFF1, Busy low at cycle 4.
//  MADDU HiIn=0 LoIn=FFFFFFFF A=1 B=1 -> Hi=00000001, Lo=00000000 (carry propagated).
//  DIV A=-7 B=2 -> WriteEn at cycle 34, Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU A=7 B=2 -> Lo=3, Hi=1.
//  DIVU in flight, Start MTLO at cycle 5 -> ignored. Only the DIVU write occurs, and Busy holds to WB.
//  Rst at DIV cycle 10 -> next cycle Busy=0 with no WriteEn ever. A fresh MTHI A=0x1234 then writes Hi=0x1234 at cycle 1.
//  DIV B=0 with macro -> DivZero pulse and no WriteEn. Without macro, A=9 -> Lo=FFFFFFFF, Hi=9 written.

Source files
------------

// File: rtl/hilo_muldiv_controller.sv
// HI/LO multiply/divide sequencer: runs one mul/div/move-to op at a time, stalls the core via Busy,
// and writes the HI/LO file with a single WriteEn strobe. Optional HILO_CTRL_DIVZERO_EN adds DivZero.
module hilo_muldiv_controller #(
    parameter int MUL_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] HiIn,
    input  logic [31:0] LoIn,
    output logic        Busy,
    output logic        WriteEn,
    output logic [31:0] WriteHiData,
    output logic [31:0] WriteLoData
`ifdef HILO_CTRL_DIVZERO_EN
    ,
    output logic        DivZero
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WB
    } state_e;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MADD  = 4'd2,
        OP_MADDU = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    state_e      r_state;
    op_e         r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_dvsr;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [63:0] r_prod;
    logic [31:0] r_cnt;
    logic [31:0] r_hi_hold;
    logic [31:0] r_lo_hold;

    logic        w_op_valid;
    logic        w_op_mul;
    logic        w_op_div;
    logic        w_div_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_is_signed;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [63:0] w_acc;
    logic [31:0] w_wb_hi;
    logic [31:0] w_wb_lo;

    assign w_op_valid = (Op <= 4'd9);
    assign w_op_mul   = (Op <= 4'd5);
    assign w_op_div   = (Op == 4'd6) || (Op == 4'd7);

`ifdef HILO_CTRL_DIVZERO_EN
    assign w_div_zero = (B == '0);
`else
    assign w_div_zero = 1'b0;
`endif

    // Only signed DIV works on magnitudes; DIVU passes operands straight through.
    assign w_a_mag = ((Op == 4'd6) && A[31]) ? (32'd0 - A) : A;
    assign w_b_mag = ((Op == 4'd6) && B[31]) ? (32'd0 - B) : B;

    assign w_is_signed = (r_op == OP_MULT) || (r_op == OP_MADD) ||
                         (r_op == OP_MSUB) || (r_op == OP_DIV);

    // Low 64 bits of the product of sign/zero-extended operands is the exact 64-bit result.
    assign w_ax   = {{32{w_is_signed & r_a[31]}}, r_a};
    assign w_bx   = {{32{w_is_signed & r_b[31]}}, r_b};
    assign w_prod = w_ax * w_bx;

    // Restoring step: trial[32] set means the partial remainder is below the divisor.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_rem_next = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_trial[32]};

    assign w_acc = {HiIn, LoIn};

    always_comb begin
        w_wb_hi = r_hi_hold;
        w_wb_lo = r_lo_hold;
        case (r_op)
            OP_MULT, OP_MULTU: {w_wb_hi, w_wb_lo} = r_prod;
            OP_MADD, OP_MADDU: {w_wb_hi, w_wb_lo} = w_acc + r_prod;
            OP_MSUB, OP_MSUBU: {w_wb_hi, w_wb_lo} = w_acc - r_prod;
            OP_DIV, OP_DIVU: begin
                w_wb_hi = r_rem;
                w_wb_lo = r_quo;
            end
            OP_MTHI: begin
                w_wb_hi = r_a;
                w_wb_lo = LoIn;
            end
            OP_MTLO: begin
                w_wb_hi = HiIn;
                w_wb_lo = r_a;
            end
            default: ;
        endcase
    end

    // HiIn/LoIn feed the write data live during WB; the hold registers keep it stable afterwards.
    assign WriteHiData = WriteEn ? w_wb_hi : r_hi_hold;
    assign WriteLoData = WriteEn ? w_wb_lo : r_lo_hold;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_dvsr    <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_hi_hold <= '0;
            r_lo_hold <= '0;
            Busy      <= 1'b0;
            WriteEn   <= 1'b0;
`ifdef HILO_CTRL_DIVZERO_EN
            DivZero   <= 1'b0;
`endif
        end else begin
            WriteEn <= 1'b0;
`ifdef HILO_CTRL_DIVZERO_EN
            DivZero <= 1'b0;
`endif
            if (WriteEn) begin
                r_hi_hold <= w_wb_hi;
                r_lo_hold <= w_wb_lo;
            end

            case (r_state)
                S_IDLE: begin
                    if (Start && w_op_valid) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_op  <= op_e'(Op);
                        r_cnt <= '0;
                        Busy  <= 1'b1;
                        if (w_op_mul) begin
                            r_state <= S_MUL;
                        end else if (w_op_div) begin
                            if (w_div_zero) begin
                                r_state <= S_WB;
`ifdef HILO_CTRL_DIVZERO_EN
                                DivZero <= 1'b1;
`endif
                            end else begin
                                r_state <= S_DIV;
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_dvsr  <= w_b_mag;
                            end
                        end else begin
                            r_state <= S_WB;
                            WriteEn <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    r_prod <= w_prod;
                    if (r_cnt == 32'(MUL_STAGES - 1)) begin
                        r_state <= S_WB;
                        WriteEn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == 32'd31) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                S_FIX: begin
                    if (r_op == OP_DIV) begin
                        if (r_a[31] ^ r_b[31]) begin
                            r_quo <= 32'd0 - r_quo;
                        end
                        if (r_a[31]) begin
                            r_rem <= 32'd0 - r_rem;
                        end
                    end
                    r_state <= S_WB;
                    WriteEn <= 1'b1;
                end

                S_WB: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Scoreboard bench for hilo_muldiv_controller: expected HI/LO writes are queued at drive time and
// matched against each WriteEn strobe, including its cycle of arrival.
module tb_hilo_muldiv_controller;

    localparam int MS      = 2;
    localparam int LAT_MUL = MS + 1;
    localparam int LAT_DIV = 34;
    localparam int LAT_MT  = 1;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HiIn;
    logic [31:0] LoIn;
    logic        Busy;
    logic        WriteEn;
    logic [31:0] WriteHiData;
    logic [31:0] WriteLoData;
`ifdef HILO_CTRL_DIVZERO_EN
    logic        DivZero;
    int          dz_seen = 0;
`endif

    hilo_muldiv_controller #(.MUL_STAGES(MS)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .Op          (Op),
        .A           (A),
        .B           (B),
        .HiIn        (HiIn),
        .LoIn        (LoIn),
        .Busy        (Busy),
        .WriteEn     (WriteEn),
        .WriteHiData (WriteHiData),
        .WriteLoData (WriteLoData)
`ifdef HILO_CTRL_DIVZERO_EN
        ,
        .DivZero     (DivZero)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_pass  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (WriteEn) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(WriteEn), 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_hi", 64'(WriteHiData), 64'(e.hi));
                check("wb_lo", 64'(WriteLoData), 64'(e.lo));
                check("wb_cycle", 64'(cyc), 64'(e.due));
            end
        end
`ifdef HILO_CTRL_DIVZERO_EN
        if (DivZero) dz_seen++;
`endif
    end

    // Drives one request at a negedge; cyc there equals the index of the accept edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo, input logic wr,
                            input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                            output int t0);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b; HiIn = hi; LoIn = lo;
        t0 = cyc;
        if (wr) sb.push_back('{hi: ehi, lo: elo, due: t0 + lat});
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int lat, input logic poke_wb, input string tag);
        check({tag, "_busy"}, 64'(Busy), 64'd1);
        for (int k = 0; k < 200; k++) begin
            if (!Busy) break;
            if (poke_wb && WriteEn) begin
                Start = 1'b1; Op = 4'd9; A = 32'hDEAD_BEEF;
            end
            @(negedge Clk);
            Start = 1'b0;
        end
        check({tag, "_idle"}, 64'(Busy), 64'd0);
        check({tag, "_idle_cycle"}, 64'(cyc), 64'(t0 + lat + 1));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int t0;
        start_op(op, a, b, hi, lo, 1'b1, ehi, elo, lat, t0);
        wait_done(t0, lat, 1'b0, tag);
    endtask

    initial begin
        int t0;
        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; HiIn = '0; LoIn = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_we", 64'(WriteEn), 64'd0);
        check("rst_hi", 64'(WriteHiData), 64'd0);
        check("rst_lo", 64'(WriteLoData), 64'd0);
        Rst = 1'b0;

        run("mult",  4'd0, 32'hFFFF_FFFD, 32'd5,        '0,       '0,           32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_MUL);
        run("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0,       '0,           32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL);
        run("maddu", 4'd3, 32'd1,        32'd1,         32'd0,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, LAT_MUL);
        run("madd",  4'd2, 32'hFFFF_FFFE, 32'd3,        32'd0,    32'd10,        32'h0000_0000, 32'h0000_0004, LAT_MUL);
        run("msub",  4'd4, 32'd1,        32'd1,         32'd0,    32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);
        run("msubu", 4'd5, 32'd2,        32'd3,         32'd1,    32'd0,         32'h0000_0000, 32'hFFFF_FFFA, LAT_MUL);
        run("div_neg",  4'd6, 32'hFFFF_FFF9, 32'd2,        '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
        run("divu",     4'd7, 32'd7,        32'd2,         '0, '0, 32'h0000_0001, 32'h0000_0003, LAT_DIV);
        run("div_negb", 4'd6, 32'd7,        32'hFFFF_FFFE, '0, '0, 32'h0000_0001, 32'hFFFF_FFFD, LAT_DIV);
        run("div_wrap", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 32'h0000_0000, 32'h8000_0000, LAT_DIV);
        run("divu_big", 4'd7, 32'hFFFF_FFFF, 32'd10,       '0, '0, 32'h0000_0005, 32'h1999_9999, LAT_DIV);
        run("mthi", 4'd8, 32'h0000_1234, 32'd0, 32'h1111_1111, 32'h0000_AAAA, 32'h0000_1234, 32'h0000_AAAA, LAT_MT);
        run("mtlo", 4'd9, 32'h0000_0055, 32'd0, 32'h0000_0077, 32'h2222_2222, 32'h0000_0077, 32'h0000_0055, LAT_MT);

        repeat (3) @(negedge Clk);
        check("hold_hi", 64'(WriteHiData), 64'h77);
        check("hold_lo", 64'(WriteLoData), 64'h55);

        @(negedge Clk);
        Start = 1'b1; Op = 4'd12; A = 32'h1;
        @(negedge Clk);
        Start = 1'b0;
        check("bad_op_busy", 64'(Busy), 64'd0);
        repeat (3) @(negedge Clk);
        check("bad_op_busy_later", 64'(Busy), 64'd0);

        // DIVU in flight: MTLO at cycle 5 and another in the WB cycle are both dropped.
        start_op(4'd7, 32'd100, 32'd7, '0, '0, 1'b1, 32'd2, 32'd14, LAT_DIV, t0);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = 4'd9; A = 32'hCAFE_F00D;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(t0, LAT_DIV, 1'b1, "divu_ignore");

        start_op(4'd6, 32'd100, 32'd3, '0, '0, 1'b0, '0, '0, 0, t0);
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_we", 64'(WriteEn), 64'd0);
        check("midrst_hi", 64'(WriteHiData), 64'd0);
        repeat (40) @(negedge Clk);
        check("midrst_busy_later", 64'(Busy), 64'd0);
        run("mthi_after_rst", 4'd8, 32'h0000_1234, 32'd0, 32'h0, 32'h0000_0005, 32'h0000_1234, 32'h0000_0005, LAT_MT);

`ifdef HILO_CTRL_DIVZERO_EN
        start_op(4'd6, 32'd9, 32'd0, '0, '0, 1'b0, '0, '0, 0, t0);
        check("dz_pulse", 64'(DivZero), 64'd1);
        check("dz_no_we", 64'(WriteEn), 64'd0);
        @(negedge Clk);
        check("dz_clear", 64'(DivZero), 64'd0);
        check("dz_idle", 64'(Busy), 64'd0);
        check("dz_count", 64'(dz_seen), 64'd1);
`else
        run("div_zero", 4'd6, 32'd9, 32'd0, '0, '0, 32'h0000_0009, 32'hFFFF_FFFF, LAT_DIV);
`endif

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
